// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback-select stage.
package wb_pkg;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2,
        SRC_IMM  = 2'd3
    } src_e;

    // Encoding 3 is left undefined on purpose: it behaves as LD_WORD.
    typedef enum logic [1:0] {
        LD_WORD   = 2'd0,
        LD_BYTE_U = 2'd1,
        LD_BYTE_S = 2'd2
    } ld_mode_e;

    typedef enum logic {
        RUN      = 1'b0,
        WAIT_MEM = 1'b1
    } state_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/wb_load_ext.sv
// Byte-lane select and zero/sign extension of memory read data.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter  int DATA_W = 16,
    localparam int SEL_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] ext
);

    logic [7:0] lane;

    assign lane = data[8*sel +: 8];

    // NOTE: ext is written on every path (default arm), so no latch is inferred.
    always_comb begin
        case (ld_mode_e'(mode))
            LD_BYTE_U: ext = {{(DATA_W-8){1'b0}}, lane};
            LD_BYTE_S: ext = {{(DATA_W-8){lane[7]}}, lane};
            default:   ext = data;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback stage: selects ALU/MEM/LINK/IMM result, stalls on late load data,
// and guards the stall with a watchdog and a saturating stall counter.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter  int DATA_W     = 16,
    parameter  int REG_ADDR_W = 4,
    parameter  int TIMEOUT    = 255,
    localparam int SEL_W      = $clog2(DATA_W / 8)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_src,
    input  logic [1:0]             in_ld_mode,
    input  logic [SEL_W-1:0]       in_byte_sel,
    input  logic [REG_ADDR_W-1:0]  in_rd,
    input  logic                   in_we,
    input  logic [DATA_W-1:0]      alu_result,
    input  logic [DATA_W-1:0]      link_value,
    input  logic [DATA_W-1:0]      imm_value,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   mem_rvalid,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [REG_ADDR_W-1:0]  wb_rd,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e                  state, next_state;
    logic [WD_W-1:0]         wd_cnt;
    logic [REG_ADDR_W-1:0]   pend_rd;
    logic                    pend_we;
    logic [1:0]              pend_mode;
    logic [SEL_W-1:0]        pend_sel;

    logic                    do_wb, do_latch, wd_inc, err_set;
    logic [1:0]              ext_mode;
    logic [SEL_W-1:0]        ext_sel;
    logic [DATA_W-1:0]       mem_ext, wb_data_nxt;

    // One extender serves both the same-cycle and the post-stall capture.
    assign ext_mode = (state == WAIT_MEM) ? pend_mode : in_ld_mode;
    assign ext_sel  = (state == WAIT_MEM) ? pend_sel  : in_byte_sel;

    wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
        .data (mem_rdata),
        .mode (ext_mode),
        .sel  (ext_sel),
        .ext  (mem_ext)
    );

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        do_wb      = 1'b0;
        do_latch   = 1'b0;
        wd_inc     = 1'b0;
        err_set    = 1'b0;
        case (state)
            RUN: begin
                in_ready = !flush;
                if (in_valid && !flush) begin
                    if (src_e'(in_src) == SRC_MEM && !mem_rvalid) begin
                        do_latch   = 1'b1;
                        next_state = WAIT_MEM;
                    end else begin
                        do_wb = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // flush outranks both arriving data and watchdog expiry
                if (flush) begin
                    next_state = RUN;
                end else if (mem_rvalid) begin
                    do_wb      = 1'b1;
                    next_state = RUN;
                end else begin
                    wd_inc = 1'b1;
                    if (wd_cnt == WD_LAST) begin
                        err_set    = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            default: next_state = RUN;
        endcase
    end

    always_comb begin
        wb_data_nxt = mem_ext;
        if (state == RUN) begin
            case (src_e'(in_src))
                SRC_ALU:  wb_data_nxt = alu_result;
                SRC_LINK: wb_data_nxt = link_value;
                SRC_IMM:  wb_data_nxt = imm_value;
                default:  wb_data_nxt = mem_ext;
            endcase
        end
    end

    // NOTE: all sequential state uses non-blocking assignments to avoid
    // simulation races between processes sampling on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
            stall_cycles <= '0;
            wd_cnt       <= '0;
            pend_rd      <= '0;
            pend_we      <= 1'b0;
            pend_mode    <= '0;
            pend_sel     <= '0;
        end else begin
            wb_valid <= do_wb;
            if (do_wb) begin
                wb_data <= wb_data_nxt;
                wb_rd   <= (state == WAIT_MEM) ? pend_rd : in_rd;
                wb_we   <= (state == WAIT_MEM) ? pend_we : in_we;
            end
            if (do_latch) begin
                pend_rd   <= in_rd;
                pend_we   <= in_we;
                pend_mode <= in_ld_mode;
                pend_sel  <= in_byte_sel;
                wd_cnt    <= '0;
            end
            if (wd_inc) begin
                wd_cnt <= wd_cnt + 1'b1;
                if (stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
            end
            if (err_set) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed plus randomized check of wb_select_stage against a transaction-level model.
module tb_wb_select_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [1:0]  in_src, in_ld_mode;
    logic        in_byte_sel;
    logic [3:0]  in_rd;
    logic        in_we;
    logic [15:0] alu_result, link_value, imm_value, mem_rdata;
    logic        mem_rvalid, flush;
    logic        wb_valid, wb_we;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        timeout_err;
    logic [15:0] stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    logic        exp_valid, exp_we, exp_err;
    logic [3:0]  exp_rd;
    logic [15:0] exp_data, exp_stall;

    wb_select_stage #(.DATA_W(16), .REG_ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_ld_mode(in_ld_mode), .in_byte_sel(in_byte_sel),
        .in_rd(in_rd), .in_we(in_we), .alu_result(alu_result),
        .link_value(link_value), .imm_value(imm_value), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .flush(flush), .wb_valid(wb_valid),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte-load result from arithmetic on the lane value.
    function automatic logic [15:0] ref_ext(input logic [15:0] d, input logic [1:0] mode,
                                            input logic sel);
        int lane;
        lane = (int'(d) >> (sel ? 8 : 0)) % 256;
        if (mode == 2'd1) return 16'(lane);
        if (mode == 2'd2) return (lane >= 128) ? 16'(lane + 65280) : 16'(lane);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    task automatic expect_wb(input logic [15:0] d, input logic [3:0] rd, input logic we);
        exp_valid = 1'b1;
        exp_data  = d;
        exp_rd    = rd;
        exp_we    = we;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":valid"}, 32'(wb_valid), 32'(exp_valid));
        chk({tag, ":we"},    32'(wb_we),    32'(exp_we));
        chk({tag, ":rd"},    32'(wb_rd),    32'(exp_rd));
        chk({tag, ":data"},  32'(wb_data),  32'(exp_data));
        chk({tag, ":err"},   32'(timeout_err), 32'(exp_err));
        chk({tag, ":stall"}, 32'(stall_cycles), 32'(exp_stall));
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic scramble_inputs();
        in_valid    = 1'($urandom);
        in_src      = 2'($urandom);
        in_ld_mode  = 2'($urandom);
        in_byte_sel = 1'($urandom);
        in_rd       = 4'($urandom);
        in_we       = 1'($urandom);
        alu_result  = 16'($urandom);
        link_value  = 16'($urandom);
        imm_value   = 16'($urandom);
    endtask

    // One instruction; lat = number of data-less wait cycles before mem_rvalid.
    task automatic issue(input logic [1:0] src, input logic [1:0] mode, input logic sel,
                         input int lat, input logic [15:0] mdata, input string tag);
        logic [15:0] va, vl, vi;
        logic [3:0]  rd;
        logic        we;
        va = 16'($urandom); vl = 16'($urandom); vi = 16'($urandom);
        rd = 4'($urandom);  we = 1'($urandom);
        in_valid = 1'b1; in_src = src; in_ld_mode = mode; in_byte_sel = sel;
        in_rd = rd; in_we = we; alu_result = va; link_value = vl; imm_value = vi;
        flush = 1'b0;
        mem_rdata  = (src == 2'd1 && lat > 0) ? 16'($urandom) : mdata;
        mem_rvalid = (src != 2'd1) ? 1'($urandom) : (lat == 0);
        #1 chk({tag, ":ready_accept"}, 32'(in_ready), 32'd1);
        tick();
        if (src != 2'd1 || lat == 0) begin
            case (src)
                2'd0:    expect_wb(va, rd, we);
                2'd1:    expect_wb(ref_ext(mdata, mode, sel), rd, we);
                2'd2:    expect_wb(vl, rd, we);
                default: expect_wb(vi, rd, we);
            endcase
            idle_inputs();
            check_outs({tag, ":direct"});
            return;
        end
        for (int k = 0; k < lat && k < TO; k++) begin
            scramble_inputs();
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            #1 chk({tag, ":ready_wait"}, 32'(in_ready), 32'd0);
            tick();
            exp_stall = (exp_stall == 16'hFFFF) ? exp_stall : exp_stall + 16'd1;
        end
        if (lat >= TO) begin
            exp_err = 1'b1;
            idle_inputs();
            check_outs({tag, ":timeout"});
            #1 chk({tag, ":ready_after_to"}, 32'(in_ready), 32'd1);
            return;
        end
        scramble_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = mdata;
        #1 chk({tag, ":ready_data"}, 32'(in_ready), 32'd0);
        tick();
        expect_wb(ref_ext(mdata, mode, sel), rd, we);
        idle_inputs();
        check_outs({tag, ":stalled"});
    endtask

    initial begin
        int lat_tab[7] = '{0, 0, 1, 2, 3, 4, 6};
        rst = 1'b1;
        idle_inputs();
        in_src = 2'd0; in_ld_mode = 2'd0; in_byte_sel = 1'b0; in_rd = 4'd0; in_we = 1'b0;
        alu_result = '0; link_value = '0; imm_value = '0; mem_rdata = '0;
        exp_valid = 0; exp_we = 0; exp_rd = 0; exp_data = 0; exp_err = 0; exp_stall = 0;
        #3 check_outs("reset");
        #9 rst = 1'b0;
        tick();
        check_outs("post_reset");

        // back-to-back ALU stream
        in_valid = 1'b1; in_src = 2'd0; in_rd = 4'd5; in_we = 1'b1;
        alu_result = 16'h1111;
        tick(); expect_wb(16'h1111, 4'd5, 1'b1); check_outs("alu0");
        alu_result = 16'h2222;
        tick(); expect_wb(16'h2222, 4'd5, 1'b1); check_outs("alu1");
        alu_result = 16'h3333;
        tick(); expect_wb(16'h3333, 4'd5, 1'b1); check_outs("alu2");
        idle_inputs();
        tick(); check_outs("alu_hold");

        issue(2'd1, 2'd2, 1'b1, 3, 16'h80AA, "byte_s_stall");
        chk("byte_s_const", 32'(wb_data), 32'h0000FF80);
        chk("stall3_const", 32'(stall_cycles), 32'd3);
        issue(2'd1, 2'd1, 1'b0, 0, 16'h80AA, "byte_u_direct");
        chk("byte_u_const", 32'(wb_data), 32'h000000AA);
        chk("nostall_const", 32'(stall_cycles), 32'd3);
        issue(2'd1, 2'd0, 1'b0, TO - 1, 16'hBEEF, "expiry_data_wins");

        // flush during WAIT_MEM with data in the same cycle
        in_valid = 1'b1; in_src = 2'd1; in_rd = 4'd9; in_we = 1'b1; mem_rvalid = 1'b0;
        tick(); idle_inputs();
        tick(); exp_stall = exp_stall + 16'd1;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'h1234;
        #1 chk("flush_ready_low", 32'(in_ready), 32'd0);
        tick(); idle_inputs();
        check_outs("flush_wait");
        #1 chk("flush_ready_back", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_src = 2'd3; imm_value = 16'h0042; in_rd = 4'd3; in_we = 1'b1;
        tick(); expect_wb(16'h0042, 4'd3, 1'b1); idle_inputs();
        check_outs("imm_after_flush");

        // flush in RUN blocks the accept
        in_valid = 1'b1; in_src = 2'd0; alu_result = 16'hDEAD; flush = 1'b1;
        #1 chk("flush_run_ready", 32'(in_ready), 32'd0);
        tick(); idle_inputs();
        check_outs("flush_run");

        issue(2'd1, 2'd0, 1'b0, TO + 2, 16'h5555, "watchdog");
        tick(); check_outs("err_sticky");

        for (int i = 0; i < 40; i++)
            issue(2'($urandom), 2'($urandom), 1'($urandom),
                  lat_tab[$urandom_range(0, 6)], 16'($urandom), $sformatf("rnd%0d", i));
        tick(); check_outs("rnd_end");

        // asynchronous reset in the middle of WAIT_MEM
        in_valid = 1'b1; in_src = 2'd1; mem_rvalid = 1'b0;
        tick(); idle_inputs();
        chk("pre_rst_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1 exp_valid = 0; exp_we = 0; exp_rd = 0; exp_data = 0; exp_err = 0; exp_stall = 0;
        check_outs("mid_reset");
        #2 rst = 1'b0;
        #1 chk("ready_after_rst", 32'(in_ready), 32'd1);
        tick(); check_outs("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
